// File: rtl/ins_cache_if.sv
// Fetch and DDR read-burst bundle for the instruction-cache controller.
// The slave modport is the controller's view; the master modport is the requester/DDR side.
interface ins_cache_if #(
  parameter int ADDR_WIDTH_MEM = 16,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int ISA_WIDTH      = 30
);
  logic                      ins_req;
  logic [ADDR_WIDTH_MEM-1:0] addr_ins;
  logic                      ins_valid;
  logic [ISA_WIDTH-1:0]      ins_out;
  logic                      ins_err;
  logic                      rd_burst_req;
  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr;
  logic [9:0]                rd_burst_len;
  logic                      rd_burst_data_valid;
  logic [ISA_WIDTH-1:0]      rd_burst_data;

  modport slave (
    input  ins_req, addr_ins, rd_burst_data_valid, rd_burst_data,
    output ins_valid, ins_out, ins_err, rd_burst_req, rd_burst_addr, rd_burst_len
  );

  modport master (
    output ins_req, addr_ins, rd_burst_data_valid, rd_burst_data,
    input  ins_valid, ins_out, ins_err, rd_burst_req, rd_burst_addr, rd_burst_len
  );
endinterface

// File: rtl/ins_cache_ctrl.sv
// Instruction-cache controller: serves fetches from a local window, refilling it with one DDR burst on a miss.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module ins_cache_ctrl #(
  parameter int ISA_DEPTH       = 128,
  parameter int TOTAL_ISA_DEPTH = 128,
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int ISA_WIDTH       = 30
) (
  input  logic        clk,
  input  logic        rst,
  ins_cache_if.slave  bus,
  output logic [15:0] tag_ins,
  output logic [9:0]  load_times,
  output logic        busy
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int IDX_W = (ISA_DEPTH > 1) ? $clog2(ISA_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HIT_OUT  = 3'd1,
    MISS_REQ = 3'd2,
    FILL     = 3'd3,
    ERR_OUT  = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic                      cache_valid_q, cache_valid_d;
  logic [9:0]                valid_len_q, valid_len_d;
  logic [9:0]                rd_cnt_q, rd_cnt_d;
  logic [9:0]                len_q, len_d;
  logic [15:0]               req_addr_q, req_addr_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [15:0]               tag_q, tag_d;
  logic [9:0]                load_q, load_d;
  logic                      ins_valid_q, ins_valid_d;
  logic                      ins_err_q, ins_err_d;
  logic [ISA_WIDTH-1:0]      ins_out_q, ins_out_d;
  logic                      burst_req_q, burst_req_d;
  logic [DDR_ADDR_WIDTH-1:0] burst_addr_q, burst_addr_d;
  logic [9:0]                burst_len_q, burst_len_d;
  logic                      busy_q, busy_d;

  logic [ISA_WIDTH-1:0]      isa_mem [ISA_DEPTH];
  logic                      mem_we_s;
  logic [IDX_W-1:0]          mem_wa_s;
  logic [ISA_WIDTH-1:0]      mem_wd_s;

  logic [16:0]               addr17_s;
  logic [16:0]               rem_s;
  logic [9:0]                len_calc_s;
  logic                      oob_s;
  logic                      hit_s;
  logic [9:0]                cnt_next_s;

  // Window arithmetic, all compared at 17 bits so tag + length cannot wrap.
  always_comb begin
    addr17_s   = 17'(bus.addr_ins);
    oob_s      = (addr17_s >= 17'(TOTAL_ISA_DEPTH));
    rem_s      = 17'(TOTAL_ISA_DEPTH) - addr17_s;
    len_calc_s = (rem_s > 17'(ISA_DEPTH)) ? 10'(ISA_DEPTH) : rem_s[9:0];
    hit_s      = cache_valid_q && (addr17_s >= {1'b0, tag_q}) &&
                 (addr17_s < ({1'b0, tag_q} + 17'(valid_len_q)));
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    cache_valid_d = cache_valid_q;
    valid_len_d   = valid_len_q;
    rd_cnt_d      = rd_cnt_q;
    len_d         = len_q;
    req_addr_d    = req_addr_q;
    idx_d         = idx_q;
    tag_d         = tag_q;
    load_d        = load_q;
    burst_req_d   = burst_req_q;
    burst_addr_d  = burst_addr_q;
    burst_len_d   = burst_len_q;
    ins_valid_d   = 1'b0;
    ins_err_d     = 1'b0;
    ins_out_d     = {ISA_WIDTH{1'b0}};
    mem_we_s      = 1'b0;
    mem_wa_s      = rd_cnt_q[IDX_W-1:0];
    mem_wd_s      = bus.rd_burst_data;
    cnt_next_s    = rd_cnt_q + 10'd1;

    case (state_q)
      IDLE: begin
        if (bus.ins_req) begin
          if (oob_s) begin
            state_d = ERR_OUT;
          end else if (hit_s) begin
            state_d = HIT_OUT;
            idx_d   = IDX_W'(addr17_s - {1'b0, tag_q});
          end else begin
            state_d       = MISS_REQ;
            len_d         = len_calc_s;
            req_addr_d    = 16'(bus.addr_ins);
            rd_cnt_d      = 10'd0;
            cache_valid_d = 1'b0;
            burst_req_d   = 1'b1;
            burst_addr_d  = DDR_ADDR_WIDTH'(bus.addr_ins) << 3;
            burst_len_d   = len_calc_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HIT_OUT: begin
        ins_valid_d = 1'b1;
        ins_out_d   = isa_mem[idx_q];
        state_d     = IDLE;
      end
      ERR_OUT: begin
        ins_valid_d = 1'b1;
        ins_err_d   = 1'b1;
        state_d     = IDLE;
      end
      MISS_REQ, FILL: begin
        if (bus.rd_burst_data_valid) begin
          mem_we_s    = 1'b1;
          burst_req_d = 1'b0;
          // The requested word sits at the window base, so the reply reads index 0.
          if (cnt_next_s == len_q) begin
            tag_d         = req_addr_q;
            valid_len_d   = len_q;
            cache_valid_d = 1'b1;
            load_d        = (load_q == 10'd1023) ? load_q : (load_q + 10'd1);
            rd_cnt_d      = 10'd0;
            idx_d         = {IDX_W{1'b0}};
            state_d       = HIT_OUT;
          end else begin
            rd_cnt_d = cnt_next_s;
            state_d  = FILL;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cache_valid_q <= 1'b0;
      valid_len_q   <= 10'd0;
      rd_cnt_q      <= 10'd0;
      len_q         <= 10'd0;
      req_addr_q    <= 16'd0;
      idx_q         <= {IDX_W{1'b0}};
      tag_q         <= 16'd0;
      load_q        <= 10'd0;
      ins_valid_q   <= 1'b0;
      ins_err_q     <= 1'b0;
      ins_out_q     <= {ISA_WIDTH{1'b0}};
      burst_req_q   <= 1'b0;
      burst_addr_q  <= {DDR_ADDR_WIDTH{1'b0}};
      burst_len_q   <= 10'd0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cache_valid_q <= cache_valid_d;
      valid_len_q   <= valid_len_d;
      rd_cnt_q      <= rd_cnt_d;
      len_q         <= len_d;
      req_addr_q    <= req_addr_d;
      idx_q         <= idx_d;
      tag_q         <= tag_d;
      load_q        <= load_d;
      ins_valid_q   <= ins_valid_d;
      ins_err_q     <= ins_err_d;
      ins_out_q     <= ins_out_d;
      burst_req_q   <= burst_req_d;
      burst_addr_q  <= burst_addr_d;
      burst_len_q   <= burst_len_d;
      busy_q        <= busy_d;
    end
  end

  // Window storage; contents are meaningless until a fill completes.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      isa_mem[mem_wa_s] <= mem_wd_s;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Saturating counters of fetches leaving IDLE as a hit or a miss.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == IDLE) && (state_d == HIT_OUT) && (hit_cnt_q != 32'hFFFF_FFFF)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
    if ((state_q == IDLE) && (state_d == MISS_REQ) && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  assign bus.ins_valid     = ins_valid_q;
  assign bus.ins_out       = ins_out_q;
  assign bus.ins_err       = ins_err_q;
  assign bus.rd_burst_req  = burst_req_q;
  assign bus.rd_burst_addr = burst_addr_q;
  assign bus.rd_burst_len  = burst_len_q;
  assign tag_ins           = tag_q;
  assign load_times        = load_q;
  assign busy              = busy_q;

endmodule

// File: doc/ins_cache_ctrl.md
Name: ins_cache_ctrl

Overview:
- Instruction-cache controller for the AP control path. It serves instruction fetches from a local window of ISA_DEPTH instructions.
- On a miss it fetches a new window from DDR with one read burst, fills the array, updates tag_ins and load_times, then returns the requested instruction.
- Sits between the instruction fetch/decoder (upstream requester) and the DDR read-burst interface (downstream).
- Its window-hit, burst-length and address arithmetic sit alongside the instruction-cache arithmetic helper block.

Parameters:
- ISA_DEPTH, 128, instructions held in the cache window.
- TOTAL_ISA_DEPTH, 128, instructions in program memory; valid addresses are 0..TOTAL_ISA_DEPTH-1.
- DDR_ADDR_WIDTH, 28, DDR byte-address width.
- ADDR_WIDTH_MEM, 16, instruction address width.
- ISA_WIDTH, 30, instruction word width (OPCODE 4 + CAM addr 8 + oprand2 2 + mem addr 16).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ins_req  in  1  fetch request; held high until ins_valid.
- addr_ins  in  ADDR_WIDTH_MEM  fetch address; stable while ins_req is high.
- ins_valid  out  1  one-cycle pulse; ins_out and ins_err are valid this cycle.
- ins_out  out  ISA_WIDTH  fetched instruction.
- ins_err  out  1  pulses with ins_valid when addr_ins >= TOTAL_ISA_DEPTH.
- rd_burst_req  out  1  DDR burst read request.
- rd_burst_addr  out  DDR_ADDR_WIDTH  burst start byte address = addr_ins<<3.
- rd_burst_len  out  10  burst length in instructions.
- rd_burst_data_valid  in  1  one instruction beat per cycle.
- rd_burst_data  in  ISA_WIDTH  beat data.
- tag_ins  out  16  base address of the current window.
- load_times  out  10  count of completed fills; saturates at 1023.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; cache_valid=0; valid_len=0; rd_cnt_isa=0; state=IDLE. Array contents are don't-care.
- States: IDLE, HIT_OUT, MISS_REQ, FILL, ERR_OUT.
- Hit condition: cache_valid && addr_ins >= tag_ins && addr_ins < tag_ins + valid_len. Compare at 17 bits so the sum cannot wrap.
- IDLE with ins_req high:
  - addr_ins >= TOTAL_ISA_DEPTH -> ERR_OUT.
  - Hit -> HIT_OUT, with array read index = addr_ins - tag_ins.
  - Otherwise -> MISS_REQ, latching len = min(ISA_DEPTH, TOTAL_ISA_DEPTH - addr_ins).
- HIT_OUT: ins_valid=1, ins_out=array[index] from a registered read. Next state IDLE. Hit latency: ins_valid 2 cycles after ins_req is sampled.
- ERR_OUT: ins_valid=1, ins_err=1, ins_out=0, then IDLE. Cache state is unchanged.
- MISS_REQ:
  - On entry: cache_valid=0; rd_burst_addr and rd_burst_len are registered.
  - rd_burst_req stays high until the first rd_burst_data_valid beat, and drops the cycle after that beat.
  - The first beat is written to array[0]; go to FILL.
- FILL:
  - Each valid beat writes array[rd_cnt_isa], then rd_cnt_isa increments.
  - When the beat making rd_cnt_isa == len is written: tag_ins=latched addr, valid_len=len, cache_valid=1, load_times+1, rd_cnt_isa=0; go to HIT_OUT with index 0.
- Beats arriving outside MISS_REQ/FILL, or beyond len, are ignored.
- ins_req is not re-sampled while busy.
- ins_req dropped early: a fill in progress still completes; ins_valid is still pulsed once.
- Reset mid-fill returns everything to reset values; stray beats that follow are ignored in IDLE.
- Arithmetic: len, index and rd_cnt_isa are 10-bit unsigned. rd_burst_addr is zero-extended to DDR_ADDR_WIDTH before the shift.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- When defined, adds two outputs, hit_cnt[31:0] and miss_cnt[31:0], both reset to 0:
  - hit_cnt increments on the IDLE->HIT_OUT transition.
  - miss_cnt increments on IDLE->MISS_REQ.
  - Both saturate at all-ones; ERR_OUT counts toward neither.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Cold fetch addr 0 after reset -> rd_burst_req, rd_burst_addr=0, rd_burst_len=128. Feed 128 beats (data=index) -> ins_out=0, tag_ins=0, load_times=1.
- Then fetch addr 5 -> no burst; ins_valid 2 cycles after ins_req; ins_out=5.
- Parameters ISA_DEPTH=32, TOTAL_ISA_DEPTH=40; fetch addr 20 -> rd_burst_len=20, rd_burst_addr=160. Fetch addr 39 -> hit, index 19. Fetch addr 19 -> miss; load_times=2.
- Fetch addr 40 with TOTAL_ISA_DEPTH=40 -> ins_valid=1, ins_err=1, ins_out=0; no burst; tag_ins unchanged.
- Reset asserted after 10 beats of a fill, then 5 stray beats -> outputs 0, busy=0, cache_valid=0. Next fetch is a miss.
- With ICACHE_PERF_CNT_EN: miss addr 0, hits at 1 and 2, error at 200 -> hit_cnt=2, miss_cnt=1.
